// File: rtl/hwpe_ctrl_regfile_reader_pkg.sv
// Shared definitions for the HWPE control register-file reader.
// Holds the reader FSM state encoding and the depth of the output buffer
// that absorbs the register file's one-cycle read latency.
package hwpe_ctrl_package;

    // Reader sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } regfile_reader_state_t;

    // Output buffer depth: one word being presented plus one word returning
    // from the register file is all that sustained 1 word/cycle needs.
    localparam int unsigned REGFILE_READER_DEPTH = 2;

endpackage

// File: rtl/hwpe_ctrl_regfile_reader_fifo2.sv
// Two-entry FIFO holding {addr, data, last} words on their way out of the
// register-file reader.
// Ports:
//   clk_i, rst_i, clear_i    clock, synchronous reset and soft clear (both flush)
//   push_i, push_*_i         write one entry
//   pop_i                    remove the head entry (caller gates with valid_o)
//   valid_o                  FIFO not empty
//   addr_o/data_o/last_o     head entry, held until popped
//   occ_o                    current occupancy, 0..2
module hwpe_ctrl_reader_fifo2
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [ADDR_WIDTH-1:0] push_addr_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  push_last_i,
    input  logic                  pop_i,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o,
    output logic [1:0]            occ_o
);

    localparam int unsigned EntryWidth = ADDR_WIDTH + DATA_WIDTH + 1;

    logic [EntryWidth-1:0] mem_q [REGFILE_READER_DEPTH];
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [1:0]            occ_q;

    // Storage is cleared on flush as well so the head outputs read as zero
    // out of reset rather than exposing stale words.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= {push_addr_i, push_data_i, push_last_i};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign {addr_o, data_o, last_o} = mem_q[rd_ptr_q];
    assign valid_o                  = (occ_q != 2'd0);
    assign occ_o                    = occ_q;

endmodule

// File: rtl/hwpe_ctrl_regfile_reader.sv
// Read-side sequencer for the HWPE control register file. On start it walks a
// window of count words from base_addr (wrapping modulo 2^ADDR_WIDTH) and
// streams them out on a valid/ready interface with their source address.
// Ports:
//   clk_i, rst_i, clear_i    clock, synchronous reset, synchronous soft clear
//   start_i, base_addr_i,
//   count_i                  job command, sampled only while idle
//   busy_o, done_o           job status; done_o pulses once per job
//   rf_ren_o, rf_raddr_o     register-file read port (combinational)
//   rf_rdata_i               read data, valid the cycle after rf_ren_o
//   out_valid_o/out_ready_i  output handshake
//   out_data_o, out_addr_o,
//   out_last_o               output word, source address, end-of-window flag
module hwpe_ctrl_regfile_reader
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   count_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  rf_ren_o,
    output logic [ADDR_WIDTH-1:0] rf_raddr_o,
    input  logic [DATA_WIDTH-1:0] rf_rdata_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [ADDR_WIDTH-1:0] out_addr_o,
    output logic                  out_last_o
);

    localparam logic [ADDR_WIDTH:0] CntOne = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [2:0]          Depth  = 3'(REGFILE_READER_DEPTH);

    regfile_reader_state_t  state_q;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic [ADDR_WIDTH:0]    count_q;
    logic [ADDR_WIDTH:0]    issued_q, issued_d;
    logic [ADDR_WIDTH:0]    sent_q, sent_d;
    logic                   inflight_q;
    logic [ADDR_WIDTH-1:0]  inflight_addr_q;
    logic                   inflight_last_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   pop;
    logic                   issue;
    logic                   issue_last;
    logic [2:0]             credit_used;
    logic [1:0]             fifo_occ;

    assign pop = out_valid_o && out_ready_i;

    // A read may only be issued if the buffer will have room for it when its
    // data returns next cycle. Counting the word already in flight and
    // crediting this cycle's pop keeps occupancy at or below the depth while
    // still allowing one issue per cycle when the consumer keeps up.
    assign credit_used = {1'b0, fifo_occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue       = (state_q == RUN) && (issued_q < count_q) && (credit_used < Depth);
    assign issue_last  = (issued_q == count_q - CntOne);
    assign issued_d    = issued_q + CntOne;
    assign sent_d      = sent_q + CntOne;

    // The register file clears its address register when ReadEnable is low,
    // so the address is forced to zero whenever no read is issued.
    assign rf_ren_o   = issue;
    assign rf_raddr_o = issue ? (base_q + issued_q[ADDR_WIDTH-1:0]) : '0;

    // Sequencer FSM with registered busy/done. The in-flight tracker records
    // each issued read so the returning data can be paired with its address
    // and last flag when it is pushed into the buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q         <= IDLE;
            base_q          <= '0;
            count_q         <= '0;
            issued_q        <= '0;
            sent_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            inflight_q      <= issue;
            inflight_addr_q <= rf_raddr_o;
            inflight_last_q <= issue_last;
            done_q          <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        if (count_i != '0) begin
                            base_q   <= base_addr_i;
                            count_q  <= count_i;
                            issued_q <= '0;
                            sent_q   <= '0;
                            state_q  <= RUN;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        issued_q <= issued_d;
                    end
                    if (pop) begin
                        sent_q <= sent_d;
                        if (sent_q == count_q - CntOne) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    hwpe_ctrl_reader_fifo2 #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .push_i      (inflight_q),
        .push_addr_i (inflight_addr_q),
        .push_data_i (rf_rdata_i),
        .push_last_i (inflight_last_q),
        .pop_i       (pop),
        .valid_o     (out_valid_o),
        .addr_o      (out_addr_o),
        .data_o      (out_data_o),
        .last_o      (out_last_o),
        .occ_o       (fifo_occ)
    );

    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_hwpe_ctrl_regfile_reader.sv
// Testbench for hwpe_ctrl_regfile_reader. A behavioural register file returns
// 0xA000_0000 + address one cycle after each read. Expected words are queued
// when a job is started and a separate monitor compares every handshaken
// output word against the queue head.
module tb_hwpe_ctrl_regfile_reader;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } expWord_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] baseAddr = '0;
    logic [AW:0]   count = '0;
    logic          busy;
    logic          done;
    logic          rfRen;
    logic [AW-1:0] rfRaddr;
    logic [DW-1:0] rfRdata = '0;
    logic          outValid;
    logic          outReady = 1'b1;
    logic [DW-1:0] outData;
    logic [AW-1:0] outAddr;
    logic          outLast;

    expWord_t sbQ[$];
    int errors = 0;
    int checks = 0;
    int doneCount = 0;
    int popCount = 0;

    hwpe_ctrl_regfile_reader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .start_i     (start),
        .base_addr_i (baseAddr),
        .count_i     (count),
        .busy_o      (busy),
        .done_o      (done),
        .rf_ren_o    (rfRen),
        .rf_raddr_o  (rfRaddr),
        .rf_rdata_i  (rfRdata),
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .out_data_o  (outData),
        .out_addr_o  (outAddr),
        .out_last_o  (outLast)
    );

    // Free-running clock
    initial begin
        forever #5 clk = ~clk;
    end

    // Register file model: data one cycle after ReadEnable, garbage otherwise
    always @(posedge clk) begin
        rfRdata <= rfRen ? (32'hA000_0000 + {27'd0, rfRaddr}) : 32'hDEAD_BEEF;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise start with a command; optionally queue the words it should produce
    task automatic applyStimulus(input logic [AW-1:0] b, input logic [AW:0] n, input bit expectWords);
        expWord_t w;
        logic [AW-1:0] a;
        start    = 1'b1;
        baseAddr = b;
        count    = n;
        if (expectWords) begin
            for (int k = 0; k < int'(n); k++) begin
                a      = b + AW'(k);
                w.addr = a;
                w.data = 32'hA000_0000 + {27'd0, a};
                w.last = (k == int'(n) - 1);
                sbQ.push_back(w);
            end
        end
    endtask

    // Job with out_ready held high: checks the cycle-exact timeline
    task automatic runTimedJob(input logic [AW-1:0] b, input logic [AW:0] n);
        int nWords = int'(n);
        int doneBefore = doneCount;
        outReady = 1'b1;
        applyStimulus(b, n, 1'b1);
        for (int c = 0; c <= nWords + 4; c++) begin
            @(negedge clk);
            if (nWords == 0) begin
                checkOutput($sformatf("zero_valid_c%0d", c), outValid, 1'b0);
                checkOutput($sformatf("zero_done_c%0d", c), done, (c == 1));
                checkOutput($sformatf("zero_busy_c%0d", c), busy, (c == 1));
            end else begin
                checkOutput($sformatf("valid_b%0d_c%0d", b, c), outValid, (c >= 3 && c <= nWords + 2));
                checkOutput($sformatf("done_b%0d_c%0d", b, c), done, (c == nWords + 3));
                checkOutput($sformatf("busy_b%0d_c%0d", b, c), busy, (c >= 1 && c <= nWords + 3));
                if (c == 1) begin
                    checkOutput("first_ren", rfRen, 1'b1);
                    checkOutput("first_raddr", rfRaddr, b);
                end
            end
            step();
            start = 1'b0;
        end
        checkOutput("job_done_pulses", doneCount - doneBefore, 1);
        checkOutput("job_sb_drained", sbQ.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every handshake, checks output stability
    // across stalls, and counts done pulses.
    initial begin
        expWord_t e;
        bit prevStall = 1'b0;
        logic [DW-1:0] prevData = '0;
        logic [AW-1:0] prevAddr = '0;
        logic prevLast = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (done) doneCount++;
                checkOutput("occ_le_2", (dut.u_fifo.occ_q <= 2'd2), 1'b1);
                if (prevStall && outValid) begin
                    checkOutput("stall_data", outData, prevData);
                    checkOutput("stall_addr", outAddr, prevAddr);
                    checkOutput("stall_last", outLast, prevLast);
                end
                if (outValid && outReady) begin
                    popCount++;
                    checkOutput("word_expected", (sbQ.size() != 0), 1'b1);
                    if (sbQ.size() != 0) begin
                        e = sbQ.pop_front();
                        checkOutput("out_data", outData, e.data);
                        checkOutput("out_addr", outAddr, e.addr);
                        checkOutput("out_last", outLast, e.last);
                    end
                end
                prevStall = outValid && !outReady;
                prevData  = outData;
                prevAddr  = outAddr;
                prevLast  = outLast;
            end else begin
                prevStall = 1'b0;
            end
        end
    end

    initial begin
        int doneBefore;
        int popBefore;

        // Reset with start held: nothing may happen
        rst = 1'b1;
        start = 1'b1;
        count = 7'd4;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_ren", rfRen, 1'b0);
        checkOutput("rst_raddr", rfRaddr, 5'd0);
        checkOutput("rst_valid", outValid, 1'b0);
        checkOutput("rst_data", outData, 32'd0);
        checkOutput("rst_addr", outAddr, 5'd0);
        checkOutput("rst_last", outLast, 1'b0);
        step();
        rst = 1'b0;
        start = 1'b0;
        count = '0;
        @(negedge clk);
        checkOutput("post_rst_busy", busy, 1'b0);
        step();

        // Basic window and wrap-around window
        $display("[TB] basic base=3 count=4");
        runTimedJob(5'd3, 7'd4);
        $display("[TB] wrap base=30 count=4");
        runTimedJob(5'd30, 7'd4);

        // Zero-length job
        $display("[TB] zero count");
        runTimedJob(5'd7, 7'd0);

        // Random backpressure
        $display("[TB] backpressure base=0 count=8");
        doneBefore = doneCount;
        popBefore = popCount;
        outReady = 1'($urandom_range(0, 1));
        applyStimulus(5'd0, 7'd8, 1'b1);
        for (int c = 0; c < 300; c++) begin
            step();
            start = 1'b0;
            outReady = 1'($urandom_range(0, 1));
            if (doneCount != doneBefore) break;
        end
        outReady = 1'b1;
        step();
        checkOutput("bp_done_pulses", doneCount - doneBefore, 1);
        checkOutput("bp_words", popCount - popBefore, 8);
        checkOutput("bp_sb_drained", sbQ.size(), 0);

        // Start pulsed during RUN is ignored
        $display("[TB] start during busy");
        doneBefore = doneCount;
        popBefore = popCount;
        applyStimulus(5'd5, 7'd4, 1'b1);
        step();
        start = 1'b0;
        step();
        applyStimulus(5'd20, 7'd3, 1'b0);
        step();
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (doneCount != doneBefore) break;
            step();
        end
        repeat (5) step();
        checkOutput("busy_start_done_pulses", doneCount - doneBefore, 1);
        checkOutput("busy_start_words", popCount - popBefore, 4);
        checkOutput("busy_start_idle", busy, 1'b0);

        // Clear after two of six words
        $display("[TB] clear mid-run");
        doneBefore = doneCount;
        popBefore = popCount;
        outReady = 1'b1;
        applyStimulus(5'd0, 7'd6, 1'b1);
        step();
        start = 1'b0;
        repeat (4) step();
        outReady = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        sbQ.delete();
        @(negedge clk);
        checkOutput("clr_valid", outValid, 1'b0);
        checkOutput("clr_busy", busy, 1'b0);
        checkOutput("clr_done", done, 1'b0);
        checkOutput("clr_words", popCount - popBefore, 2);
        repeat (3) step();
        checkOutput("clr_no_done", doneCount - doneBefore, 0);
        outReady = 1'b1;
        runTimedJob(5'd10, 7'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hwpe_ctrl_regfile_reader.md
# hwpe_ctrl_regfile_reader

Read-side sequencer for the HWPE control register file: on a `start` command it walks a contiguous window of register-file words and streams them out on a valid/ready interface. It drives the register file's read port, where the read address is registered and data returns one cycle later. A two-entry buffer absorbs that latency under backpressure. The block sits between the register file and job-context consumers, such as a streamer config loader or a context-swap unit.

## Interface
- `ADDR_WIDTH`, default 5: register-file address width; window addresses wrap modulo 2^ADDR_WIDTH.
- `DATA_WIDTH`, default 32: word width.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `clear`  in  1  synchronous soft clear, active-high; same effect as `rst`.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first word address; sampled with `start`.
- `count`  in  ADDR_WIDTH+1  number of words to read; sampled with `start`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `rf_ren`  out  1  register-file ReadEnable.
- `rf_raddr`  out  ADDR_WIDTH  register-file ReadAddr.
- `rf_rdata`  in  DATA_WIDTH  register-file ReadData; valid in the cycle after `rf_ren`=1.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  consumer ready.
- `out_data`  out  DATA_WIDTH  output word.
- `out_addr`  out  ADDR_WIDTH  source address of `out_data`.
- `out_last`  out  1  marks the final word of the window.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `start`=1 with `count`≠0: latch `base_addr` and `count`, clear `issued` and `sent` counters, go to RUN.
  - `start`=1 with `count`=0: go to DONE.
- **RUN**
  - Issue one read per cycle (`rf_ren`=1, `rf_raddr`=base+issued mod 2^AW) while issued<count and occ+inflight−pop<2.
    - occ: buffer occupancy, 0..2.
    - inflight: registered copy of last cycle's `rf_ren`.
    - pop: `out_valid`&`out_ready`.
  - The credit check is combinational from `out_ready`; this gives sustained 1 word/cycle.
  - In the cycle after an issue, `rf_rdata` and the matching address are pushed into the buffer.
  - Push and pop in the same cycle are legal; occupancy is unchanged.
  - `out_last`=1 when the head word has index count−1.
  - On the pop of the last word, go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then go to IDLE.
- `start` in RUN or DONE is ignored; no queuing.
- `rf_ren`=0 whenever no read is issued, because the register file clears its address register when ReadEnable is low.
- Addresses wrap from 2^AW−1 to 0.
- A `count` greater than 2^AW re-reads wrapped addresses. This is legal, not an error.
- Output stability: once `out_valid`=1, `out_data`, `out_addr` and `out_last` hold until the handshake.
- **Reset/clear**
  - Can occur at any time, including mid-RUN: next state is IDLE, buffer flushed, counters zeroed, in-flight read discarded.
  - Reset value of every output is 0: `busy`, `done`, `rf_ren`, `rf_raddr`, `out_valid`, `out_data`, `out_addr`, `out_last`.

## Timing
- `start` in cycle 0: `rf_ren`=1 with `rf_raddr`=base in cycle 1, `rf_rdata` in cycle 2, `out_valid`=1 in cycle 3.
- With `out_ready` held at 1: one word per cycle; N words occupy cycles 3..N+2; `done` in cycle N+3; IDLE from cycle N+4.
- `count`=0: `busy`=1 and `done`=1 in cycle 1; IDLE in cycle 2; `out_valid` never asserts.
- Buffer occupancy never exceeds 2; there is no overflow under any `out_ready` pattern.
- All outputs are registered except `rf_ren`/`rf_raddr`, which are combinational from state, counters and `out_ready`.

## Structure
- Shared package `hwpe_ctrl_package` holds:
  - the `regfile_reader_state_t` enum (IDLE/RUN/DONE);
  - the buffer-depth constant `REGFILE_READER_DEPTH`=2.
- Sub-module `hwpe_ctrl_reader_fifo2`: 2-entry FIFO of {addr, data, last} with push/pop/occupancy and synchronous flush on rst|clear.
- Top level contains the FSM, issue/sent counters and credit logic.

## Test plan
- Reset: assert `rst` for 2 cycles → all outputs 0, `busy`=0; `start` held during reset has no effect.
- Basic: regfile word k = 0xA000_0000+k; base=3, count=4, `out_ready`=1 → `out_data` 0xA0000003..0xA0000006 in cycles 3–6; `out_last` only on 0xA0000006; `done` in cycle 7.
- Wrap: base=30, count=4, AW=5 → `out_addr` sequence 30, 31, 0, 1; data matches.
- Backpressure: base=0, count=8, `out_ready` random 50% → 8 words in order, none lost or duplicated, occupancy ≤2, outputs stable while stalled.
- Zero count and busy start: count=0 → single `done`, no `out_valid`. Then `start` pulsed mid-RUN of a count=4 job → exactly 4 words, one `done`.
- Clear mid-RUN: `clear` after 2 of 6 words → IDLE next cycle, `out_valid`=0, no `done`; a fresh start base=10, count=2 → words 10, 11.
